// File: rtl/knn_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : knn_scan_if
// Description : Handshake and bus bundle between the kNN scan controller,
//               vertex memory, distance datapath and the starting top level.
// Revision    : 1.0 - initial release
// ============================================================================
interface knn_scan_if #(
    parameter int DIM    = 2,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 7
);
    localparam int DIST_W = 2*DATA_W + $clog2(DIM);

    logic                    start_in;
    logic [DIM*DATA_W-1:0]   query_in;
    logic                    mem_rd_out;
    logic [ADDR_W-1:0]       mem_addr_out;
    logic [DATA_W-1:0]       mem_data_in;
    logic                    dp_valid_out;
    logic [DATA_W-1:0]       dp_vertex_out;
    logic [DATA_W-1:0]       dp_query_out;
    logic                    dp_valid_in;
    logic [2*DATA_W-1:0]     dp_result_in;
    logic                    busy_out;
    logic                    done_out;
    logic [ADDR_W-1:0]       best_idx_out;
    logic [DIST_W-1:0]       best_dist_out;

    modport slave (
        input  start_in, query_in, mem_data_in, dp_valid_in, dp_result_in,
        output mem_rd_out, mem_addr_out, dp_valid_out, dp_vertex_out,
               dp_query_out, busy_out, done_out, best_idx_out, best_dist_out
    );

    modport master (
        output start_in, query_in, mem_data_in, dp_valid_in, dp_result_in,
        input  mem_rd_out, mem_addr_out, dp_valid_out, dp_vertex_out,
               dp_query_out, busy_out, done_out, best_idx_out, best_dist_out
    );
endinterface
`default_nettype wire

// File: rtl/knn_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : knn_scan_controller
// Description : Streams every vertex element through the distance datapath,
//               sums per-vertex terms and tracks the nearest vertex.
// Revision    : 1.0 - initial release
// ============================================================================
module knn_scan_controller #(
    parameter int DIM          = 2,
    parameter int NUM_VERTICES = 64,
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 7,
    parameter int MEM_LAT      = 2
) (
    input  logic      clk_in,
    input  logic      rst_in,
    knn_scan_if.slave bus
);
    localparam int DIST_W = 2*DATA_W + $clog2(DIM);
    localparam int D_W    = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int VCNT_W = $clog2(NUM_VERTICES + 1);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(NUM_VERTICES*DIM - 1);
    localparam logic [D_W-1:0]    c_last_d    = D_W'(DIM - 1);
    localparam logic [VCNT_W-1:0] c_num_vert  = VCNT_W'(NUM_VERTICES);
    localparam logic [VCNT_W-1:0] c_last_vert = VCNT_W'(NUM_VERTICES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_mem_rd;
    logic [ADDR_W-1:0]   r_addr;
    logic [D_W-1:0]      r_issue_d;
    logic [MEM_LAT-1:0]  r_pipe_vld;
    logic [D_W-1:0]      r_pipe_d [MEM_LAT];
    logic [DATA_W-1:0]   r_query  [DIM];
    logic [DIST_W-1:0]   r_acc;
    logic [DIST_W-1:0]   r_best_dist;
    logic [ADDR_W-1:0]   r_best_idx;
    logic [D_W-1:0]      r_term_cnt;
    logic [VCNT_W-1:0]   r_vcnt;
    logic                r_busy;
    logic                r_done;

    logic                w_accept;
    logic                w_vertex_end;
    logic [DIST_W-1:0]   w_sum;
    logic                w_tail_vld;
    logic [D_W-1:0]      w_tail_d;

    assign w_accept     = bus.dp_valid_in && (r_state == S_ISSUE || r_state == S_DRAIN);
    assign w_vertex_end = w_accept && (r_term_cnt == c_last_d);
    assign w_sum        = r_acc + DIST_W'(bus.dp_result_in);
    assign w_tail_vld   = r_pipe_vld[MEM_LAT-1];
    assign w_tail_d     = r_pipe_d[MEM_LAT-1];

    // Pairing is combinational off the tracking tail so the pair lines up with mem_data_in.
    assign bus.dp_valid_out  = w_tail_vld;
    assign bus.dp_vertex_out = w_tail_vld ? bus.mem_data_in : '0;
    assign bus.dp_query_out  = w_tail_vld ? r_query[w_tail_d] : '0;

    assign bus.mem_rd_out    = r_mem_rd;
    assign bus.mem_addr_out  = r_addr;
    assign bus.busy_out      = r_busy;
    assign bus.done_out      = r_done;
    assign bus.best_idx_out  = r_best_idx;
    assign bus.best_dist_out = r_best_dist;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= S_IDLE;
            r_mem_rd    <= 1'b0;
            r_addr      <= '0;
            r_issue_d   <= '0;
            r_pipe_vld  <= '0;
            r_acc       <= '0;
            r_best_dist <= '1;
            r_best_idx  <= '0;
            r_term_cnt  <= '0;
            r_vcnt      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            for (int i = 0; i < MEM_LAT; i++) r_pipe_d[i] <= '0;
            for (int d = 0; d < DIM; d++)     r_query[d]  <= '0;
        end else begin
            r_pipe_vld[0] <= r_mem_rd;
            r_pipe_d[0]   <= r_issue_d;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_d[i]   <= r_pipe_d[i-1];
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.start_in) begin
                        for (int d = 0; d < DIM; d++)
                            r_query[d] <= bus.query_in[d*DATA_W +: DATA_W];
                        r_addr      <= '0;
                        r_issue_d   <= '0;
                        r_acc       <= '0;
                        r_term_cnt  <= '0;
                        r_vcnt      <= '0;
                        r_best_dist <= '1;
                        r_best_idx  <= '0;
                        r_mem_rd    <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_issue_d <= (r_issue_d == c_last_d) ? '0 : r_issue_d + 1'b1;
                    if (r_addr == c_last_addr) begin
                        r_addr   <= '0;
                        r_mem_rd <= 1'b0;
                        r_state  <= S_DRAIN;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    // The last vertex may complete in this very cycle.
                    if (r_vcnt == c_num_vert || (w_vertex_end && r_vcnt == c_last_vert)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase

            if (w_accept) begin
                if (w_vertex_end) begin
                    // Strict compare keeps the lowest index on ties.
                    if (w_sum < r_best_dist) begin
                        r_best_dist <= w_sum;
                        r_best_idx  <= ADDR_W'(r_vcnt);
                    end
                    r_acc      <= '0;
                    r_term_cnt <= '0;
                    r_vcnt     <= r_vcnt + 1'b1;
                end else begin
                    r_acc      <= w_sum;
                    r_term_cnt <= r_term_cnt + 1'b1;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_knn_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_knn_scan_controller
// Description : Directed scoreboard bench with memory and datapath models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_knn_scan_controller;
    localparam int DIM     = 2;
    localparam int NV      = 4;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 3;
    localparam int MEM_LAT = 2;
    localparam int DIST_W  = 2*DATA_W + 1;
    localparam int NADDR   = NV*DIM;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    knn_scan_if #(.DIM(DIM), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    knn_scan_controller #(
        .DIM(DIM), .NUM_VERTICES(NV), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_done   = 0;
    int first_rd_cyc = 0;

    logic [DATA_W-1:0]        vmem [NADDR];
    logic [ADDR_W-1:0]        addr_q [$];
    logic [DATA_W-1:0]        qel_q  [$];
    logic [DATA_W-1:0]        vx_q   [$];
    int                       rdcyc_q[$];
    logic [ADDR_W+DIST_W-1:0] res_q  [$];
    logic [ADDR_W-1:0]        m_addr_e;
    logic [ADDR_W+DIST_W-1:0] m_res;

    function automatic logic [31:0] sq(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] d;
        d = (a > b) ? a - b : b - a;
        return 32'(d) * 32'(d);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Vertex memory: data is valid two cycles after the read strobe.
    logic [ADDR_W-1:0] m_addr1;
    always @(posedge clk) begin
        m_addr1         <= bus.mem_addr_out;
        bus.mem_data_in <= vmem[m_addr1];
    end

    // Distance datapath with three cycles of latency.
    logic [2:0]  dp_v;
    logic [31:0] dp_r [3];
    always @(posedge clk) begin
        if (rst) dp_v <= '0;
        else     dp_v <= {dp_v[1:0], bus.dp_valid_out};
        dp_r[0] <= sq(bus.dp_vertex_out, bus.dp_query_out);
        dp_r[1] <= dp_r[0];
        dp_r[2] <= dp_r[1];
    end
    assign bus.dp_valid_in  = dp_v[2];
    assign bus.dp_result_in = dp_r[2];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_rd_out) begin
                check("rd_expected", 64'(addr_q.size() != 0), 1);
                if (addr_q.size() != 0) begin
                    m_addr_e = addr_q.pop_front();
                    if (m_addr_e == 0) first_rd_cyc = cyc;
                    check("rd_addr", 64'(bus.mem_addr_out), 64'(m_addr_e));
                    check("rd_cycle", 64'(cyc - first_rd_cyc), 64'(m_addr_e));
                end
                rdcyc_q.push_back(cyc);
            end
            if (bus.dp_valid_out) begin
                check("dp_expected", 64'(qel_q.size() != 0 && rdcyc_q.size() != 0), 1);
                if (qel_q.size() != 0 && rdcyc_q.size() != 0) begin
                    check("dp_query", 64'(bus.dp_query_out), 64'(qel_q.pop_front()));
                    check("dp_vertex", 64'(bus.dp_vertex_out), 64'(vx_q.pop_front()));
                    check("dp_latency", 64'(cyc - rdcyc_q.pop_front()), 64'(MEM_LAT));
                end
            end
            if (bus.done_out) begin
                n_done++;
                check("done_expected", 64'(res_q.size() != 0), 1);
                if (res_q.size() != 0) begin
                    m_res = res_q.pop_front();
                    check("best_idx", 64'(bus.best_idx_out), 64'(m_res[DIST_W +: ADDR_W]));
                    check("best_dist", 64'(bus.best_dist_out), 64'(m_res[DIST_W-1:0]));
                end
            end
        end
    end

    task automatic load_vertices(input logic [15:0] v [NADDR]);
        for (int i = 0; i < NADDR; i++) vmem[i] = v[i];
    endtask

    // Pushes the expected scan onto the scoreboard, then pulses start in the next cycle.
    task automatic start_scan(input logic [15:0] q0, input logic [15:0] q1);
        logic [DIST_W-1:0] best;
        logic [DIST_W-1:0] s;
        logic [ADDR_W-1:0] bidx;
        best = '1;
        bidx = '0;
        for (int v = 0; v < NV; v++) begin
            s = DIST_W'(sq(vmem[2*v], q0)) + DIST_W'(sq(vmem[2*v+1], q1));
            if (s < best) begin
                best = s;
                bidx = ADDR_W'(v);
            end
        end
        res_q.push_back({bidx, best});
        for (int a = 0; a < NADDR; a++) begin
            addr_q.push_back(ADDR_W'(a));
            qel_q.push_back((a % 2 == 1) ? q1 : q0);
            vx_q.push_back(vmem[a]);
        end
        @(posedge clk); #1;
        bus.start_in = 1'b1;
        bus.query_in = {q1, q0};
        @(posedge clk); #1;
        bus.start_in = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.done_out) seen = 1'b1;
        end
        check("done_seen", 64'(seen), 1);
    endtask

    task automatic pulse_stray_start(input logic [15:0] q0, input logic [15:0] q1);
        check("busy_at_stray_start", 64'(bus.busy_out), 1);
        bus.start_in = 1'b1;
        bus.query_in = {q1, q0};
        @(posedge clk); #1;
        bus.start_in = 1'b0;
    endtask

    logic [15:0] v_set1 [NADDR];
    logic [15:0] v_max  [NADDR];

    initial begin
        v_set1 = '{16'd0, 16'd0, 16'd3, 16'd5, 16'd10, 16'd10, 16'd3, 16'd3};
        v_max  = '{default: 16'hFFFF};
        bus.start_in = 1'b0;
        bus.query_in = '0;
        load_vertices(v_set1);

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",      64'(bus.busy_out), 0);
        check("rst_done",      64'(bus.done_out), 0);
        check("rst_mem_rd",    64'(bus.mem_rd_out), 0);
        check("rst_addr",      64'(bus.mem_addr_out), 0);
        check("rst_dp_valid",  64'(bus.dp_valid_out), 0);
        check("rst_best_idx",  64'(bus.best_idx_out), 0);
        check("rst_best_dist", 64'(bus.best_dist_out), 64'h1_FFFF_FFFF);
        rst = 1'b0;

        // Basic scan with a tie between vertices 1 and 3.
        start_scan(16'd3, 16'd4);
        check("t1_busy", 64'(bus.busy_out), 1);
        wait_done(60);
        check("t1_idx",  64'(bus.best_idx_out), 1);
        check("t1_dist", 64'(bus.best_dist_out), 1);
        repeat (3) @(negedge clk);
        check("t1_done_once", 64'(n_done), 1);
        check("t1_hold_dist", 64'(bus.best_dist_out), 1);
        check("t1_idle_busy", 64'(bus.busy_out), 0);

        // Maximum-distance vertices: sum must not truncate.
        load_vertices(v_max);
        start_scan(16'd0, 16'd0);
        wait_done(60);
        check("t3_idx",  64'(bus.best_idx_out), 0);
        check("t3_dist", 64'(bus.best_dist_out), 64'h1_FFFC_0002);

        // Stray start pulses during ISSUE and DRAIN.
        load_vertices(v_set1);
        start_scan(16'd3, 16'd4);
        repeat (2) @(posedge clk);
        #1;
        check("t4_in_issue", 64'(bus.mem_rd_out), 1);
        pulse_stray_start(16'd100, 16'd200);
        repeat (5) @(posedge clk);
        #1;
        check("t4_in_drain", 64'(bus.mem_rd_out), 0);
        pulse_stray_start(16'd7, 16'd9);
        wait_done(60);
        check("t4_idx",  64'(bus.best_idx_out), 1);
        check("t4_dist", 64'(bus.best_dist_out), 1);

        // Reset in the middle of ISSUE, then a clean rescan.
        start_scan(16'd10, 16'd10);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        addr_q.delete();
        qel_q.delete();
        vx_q.delete();
        rdcyc_q.delete();
        res_q.delete();
        @(posedge clk); #1;
        check("t5_busy",      64'(bus.busy_out), 0);
        check("t5_mem_rd",    64'(bus.mem_rd_out), 0);
        check("t5_dp_valid",  64'(bus.dp_valid_out), 0);
        check("t5_best_dist", 64'(bus.best_dist_out), 64'h1_FFFF_FFFF);
        rst = 1'b0;
        start_scan(16'd3, 16'd4);
        wait_done(60);
        check("t5_idx",  64'(bus.best_idx_out), 1);
        check("t5_dist", 64'(bus.best_dist_out), 1);

        // Back-to-back scans: second start in the cycle after done.
        start_scan(16'd3, 16'd4);
        wait_done(60);
        start_scan(16'd10, 16'd10);
        check("t6_busy", 64'(bus.busy_out), 1);
        wait_done(60);
        check("t6_idx",  64'(bus.best_idx_out), 2);
        check("t6_dist", 64'(bus.best_dist_out), 0);

        repeat (4) @(negedge clk);
        check("total_done",  64'(n_done), 6);
        check("addr_q_left", 64'(addr_q.size()), 0);
        check("res_q_left",  64'(res_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
